// File: rtl/vpu_pkg.sv
// vpu_pkg: shared constants and types for the vector dot-product engine.
//   LANES / LANE_W : lane layout of a 64-bit VRF word (8 x int8)
//   AM_RW / AM_IDLE: VRF access-mode encodings for R_am / W_am
//   state_t        : sequencer states of vdot_engine
package vpu_pkg;

    localparam int          LANES   = 8;
    localparam int          LANE_W  = 8;
    localparam int          PROD_W  = 2 * LANE_W;
    localparam int          DOT_W   = PROD_W + 3;
    localparam logic [1:0]  AM_RW   = 2'b01;
    localparam logic [1:0]  AM_IDLE = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        DRAIN = 2'b10,
        WRITE = 2'b11
    } state_t;

endpackage

// File: rtl/dot8_i8.sv
// dot8_i8: combinational 8-lane signed int8 dot product.
//   a, b : 64-bit words, each 8 signed int8 lanes (lane k = bits 8k+7:8k)
//   sum  : 19-bit signed sum of the 8 lane products
module dot8_i8
    import vpu_pkg::*;
(
    input  logic [LANES*LANE_W-1:0] a,
    input  logic [LANES*LANE_W-1:0] b,
    output logic signed [DOT_W-1:0] sum
);

    logic signed [PROD_W-1:0] prod [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [LANE_W-1:0] la;
        logic signed [LANE_W-1:0] lb;
        assign la      = a[k*LANE_W +: LANE_W];
        assign lb      = b[k*LANE_W +: LANE_W];
        assign prod[k] = la * lb;
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < LANES; k++) begin
            sum = sum + {{(DOT_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
        end
    end

endmodule

// File: rtl/vdot_engine.sv
// vdot_engine: sequences paired VRF reads, accumulates the int8 dot product
// of each pair and writes the sign-extended result back to the VRF.
//   clk, rst          : clock, synchronous active-high reset
//   start             : request, only looked at while idle
//   base_addr/len/dst : first pair address, number of pairs, destination
//   busy, done        : in-progress flag, one-cycle completion pulse
//   R_am/R_addr       : VRF paired-read port; rd_data1/rd_data2 return data
//   W_am/W_addr/W_data: VRF write port
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing one paired read per cycle
// DRAIN | last read data in flight, final accumulate at exit
// WRITE | write presented to VRF for one cycle
module vdot_engine
    import vpu_pkg::*;
#(
    parameter int LEN_W = 5,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] base_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [LEN_W-1:0] dst_addr,
    output logic             busy,
    output logic             done,
    output logic [1:0]       R_am,
    output logic [LEN_W-1:0] R_addr,
    input  logic [63:0]      rd_data1,
    input  logic [63:0]      rd_data2,
    output logic [1:0]       W_am,
    output logic [LEN_W-1:0] W_addr,
    output logic [63:0]      W_data
);

    state_t                  state;
    state_t                  state_nx;
    logic [LEN_W-1:0]        cnt;
    logic [LEN_W-1:0]        dst_q;
    logic                    rv;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nx;
    logic signed [DOT_W-1:0] dot;

    dot8_i8 u_dot (
        .a   (rd_data1),
        .b   (rd_data2),
        .sum (dot)
    );

    // The VRF holds stale data when not reading, so only rv qualifies it.
    always_comb begin
        acc_nx = acc;
        if (rv) begin
            acc_nx = acc + {{(ACC_W-DOT_W){dot[DOT_W-1]}}, dot};
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (len == '0) ? WRITE : READ;
            READ:    if (cnt == '0) state_nx = DRAIN;
            DRAIN:   state_nx = WRITE;
            WRITE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            dst_q  <= '0;
            rv     <= 1'b0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            R_am   <= AM_IDLE;
            R_addr <= '0;
            W_am   <= AM_IDLE;
            W_addr <= '0;
            W_data <= '0;
        end else begin
            state <= state_nx;
            rv    <= (R_am == AM_RW);
            done  <= (state == WRITE);
            acc   <= acc_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        dst_q <= dst_addr;
                        acc   <= '0;
                        if (len != '0) begin
                            R_am   <= AM_RW;
                            R_addr <= base_addr;
                            cnt    <= len - LEN_W'(1);
                        end else begin
                            W_am   <= AM_RW;
                            W_addr <= dst_addr;
                            W_data <= '0;
                        end
                    end
                end
                READ: begin
                    if (cnt != '0) begin
                        R_addr <= R_addr + LEN_W'(2);
                        cnt    <= cnt - LEN_W'(1);
                    end else begin
                        R_am <= AM_IDLE;
                    end
                end
                DRAIN: begin
                    // Final accumulate lands on this same edge, so write acc_nx.
                    W_am   <= AM_RW;
                    W_addr <= dst_q;
                    W_data <= {{(64-ACC_W){acc_nx[ACC_W-1]}}, acc_nx};
                end
                WRITE: begin
                    W_am <= AM_IDLE;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
